// File: rtl/vga_sync_monitor.sv
// VGA sync timing monitor: measures hsync/vsync geometry against expected values,
// tracks SEARCH/ACQUIRE/LOCKED lock state and captures one probe pixel per locked frame.
module vga_sync_monitor #(
   parameter int unsigned H_TOTAL = 800,
   parameter int unsigned H_SYNC  = 96,
   parameter int unsigned V_TOTAL = 525,
   parameter int unsigned V_SYNC  = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ena,
   input  logic [7:0]  vga_in,
   input  logic [10:0] probe_x,
   input  logic [10:0] probe_y,
   output logic [1:0]  state,
   output logic        locked,
   output logic [10:0] h_count,
   output logic [10:0] v_count,
   output logic [10:0] line_len,
   output logic [10:0] frame_lines,
   output logic [7:0]  err_count,
   output logic [7:0]  frame_count,
   output logic [5:0]  pixel_rgb,
   output logic        probe_hit
);
   localparam int unsigned CW = 11;
   localparam int unsigned EW = 8;
   localparam int unsigned PW = 6;
   localparam logic [CW-1:0] CNT_MAX  = '1;
   localparam logic [EW-1:0] ERR_MAX  = '1;
   localparam logic [7:0]    PIN_IDLE = 8'h88;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [7:0]    s1_q, s2_q;
   logic [CW-1:0] h_cnt_q, h_cnt_d;
   logic [CW-1:0] v_cnt_q, v_cnt_d;
   logic [CW-1:0] line_len_q, line_len_d;
   logic [CW-1:0] frame_lines_q, frame_lines_d;
   logic [CW-1:0] hs_wid_q, hs_wid_d;
   logic [CW-1:0] vs_wid_q, vs_wid_d;
   logic          pend_q, pend_d;
   logic [EW-1:0] err_q, err_d;
   logic [EW-1:0] frm_q, frm_d;
   logic [PW-1:0] pix_q, pix_d;
   logic          hit_q, hit_d;
   logic          locked_q, locked_d;

   logic hs_start, hs_end, vs_start, vs_end, boundary, err;

   // Edge detection on the second synchroniser stage; syncs are active-low.
   always_comb begin
      hs_start = s2_q[7] & ~s1_q[7];
      hs_end   = ~s2_q[7] & s1_q[7];
      vs_start = s2_q[3] & ~s1_q[3];
      vs_end   = ~s2_q[3] & s1_q[3];
      boundary = hs_start & (pend_q | vs_start);
   end

   // Measurement counters run regardless of lock state.
   always_comb begin
      h_cnt_d       = h_cnt_q;
      v_cnt_d       = v_cnt_q;
      line_len_d    = line_len_q;
      frame_lines_d = frame_lines_q;
      hs_wid_d      = hs_wid_q;
      vs_wid_d      = vs_wid_q;
      pend_d        = pend_q;

      if (hs_start) begin
         h_cnt_d    = '0;
         line_len_d = h_cnt_q + CW'(1);
      end else if (h_cnt_q != CNT_MAX) begin
         h_cnt_d = h_cnt_q + CW'(1);
      end

      if (hs_start) begin
         hs_wid_d = CW'(1);
      end else if (!s1_q[7] && hs_wid_q != CNT_MAX) begin
         hs_wid_d = hs_wid_q + CW'(1);
      end

      // vsync width is measured in hs_starts seen while vsync is low
      if (vs_start) begin
         vs_wid_d = hs_start ? CW'(1) : '0;
      end else if (!s1_q[3] && hs_start && vs_wid_q != CNT_MAX) begin
         vs_wid_d = vs_wid_q + CW'(1);
      end

      if (vs_start) pend_d = 1'b1;
      if (boundary) pend_d = 1'b0;

      if (boundary) begin
         frame_lines_d = v_cnt_q + CW'(1);
         v_cnt_d       = '0;
      end else if (hs_start && v_cnt_q != CNT_MAX) begin
         v_cnt_d = v_cnt_q + CW'(1);
      end
   end

   // Timing violations; only acted upon outside SEARCH.
   always_comb begin
      err = 1'b0;
      if (hs_start && (h_cnt_q + CW'(1)) != CW'(H_TOTAL))        err = 1'b1;
      if (hs_end && hs_wid_q != CW'(H_SYNC))                      err = 1'b1;
      if (vs_end && vs_wid_q != CW'(V_SYNC))                      err = 1'b1;
      if (boundary && (v_cnt_q + CW'(1)) != CW'(V_TOTAL))         err = 1'b1;
      if (!hs_start && h_cnt_q == (CNT_MAX - CW'(1)))             err = 1'b1;
      if (state_q == SEARCH)                                      err = 1'b0;
   end

   // Lock FSM next state, error/frame counters and probe capture.
   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      frm_d   = frm_q;
      pix_d   = pix_q;
      hit_d   = 1'b0;

      case (state_q)
         SEARCH: begin
            if (boundary) state_d = ACQUIRE;
         end
         ACQUIRE: begin
            if (err)           state_d = SEARCH;
            else if (boundary) state_d = LOCKED;
         end
         LOCKED: begin
            if (err)           state_d = SEARCH;
            else if (boundary) frm_d = frm_q + EW'(1);
         end
         default: state_d = SEARCH;
      endcase

      if (err && err_q != ERR_MAX) err_d = err_q + EW'(1);

      if (state_q == LOCKED && h_cnt_q == probe_x && v_cnt_q == probe_y) begin
         hit_d = 1'b1;
         pix_d = {s2_q[4], s2_q[0], s2_q[5], s2_q[1], s2_q[6], s2_q[2]};
      end

      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= SEARCH;
         s1_q          <= PIN_IDLE;
         s2_q          <= PIN_IDLE;
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         line_len_q    <= '0;
         frame_lines_q <= '0;
         hs_wid_q      <= '0;
         vs_wid_q      <= '0;
         pend_q        <= 1'b0;
         err_q         <= '0;
         frm_q         <= '0;
         pix_q         <= '0;
         hit_q         <= 1'b0;
         locked_q      <= 1'b0;
      end else if (ena) begin
         state_q       <= state_d;
         s1_q          <= vga_in;
         s2_q          <= s1_q;
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         line_len_q    <= line_len_d;
         frame_lines_q <= frame_lines_d;
         hs_wid_q      <= hs_wid_d;
         vs_wid_q      <= vs_wid_d;
         pend_q        <= pend_d;
         err_q         <= err_d;
         frm_q         <= frm_d;
         pix_q         <= pix_d;
         hit_q         <= hit_d;
         locked_q      <= locked_d;
      end
   end

   assign state       = state_q;
   assign locked      = locked_q;
   assign h_count     = h_cnt_q;
   assign v_count     = v_cnt_q;
   assign line_len    = line_len_q;
   assign frame_lines = frame_lines_q;
   assign err_count   = err_q;
   assign frame_count = frm_q;
   assign pixel_rgb   = pix_q;
   assign probe_hit   = hit_q;
endmodule

// File: tb/tb_vga_sync_monitor.sv
// Scoreboard bench for vga_sync_monitor using a reduced 40x12 frame geometry.
module tb_vga_sync_monitor;
   localparam int unsigned HT = 40;
   localparam int unsigned HS = 6;
   localparam int unsigned VT = 12;
   localparam int unsigned VS = 2;
   localparam int PX = 25;
   localparam int PY = 7;

   localparam int F_STATE  = 0;
   localparam int F_LOCKED = 1;
   localparam int F_HCNT   = 2;
   localparam int F_VCNT   = 3;
   localparam int F_LLEN   = 4;
   localparam int F_FLINES = 5;
   localparam int F_ERR    = 6;
   localparam int F_FRM    = 7;
   localparam int F_PIX    = 8;
   localparam int F_HIT    = 9;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ena = 1'b1;
   logic [7:0]  vga_in = 8'h88;
   logic [10:0] probe_x;
   logic [10:0] probe_y;
   logic [1:0]  state;
   logic        locked;
   logic [10:0] h_count, v_count, line_len, frame_lines;
   logic [7:0]  err_count, frame_count;
   logic [5:0]  pixel_rgb;
   logic        probe_hit;

   vga_sync_monitor #(.H_TOTAL(HT), .H_SYNC(HS), .V_TOTAL(VT), .V_SYNC(VS)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .vga_in(vga_in),
      .probe_x(probe_x), .probe_y(probe_y),
      .state(state), .locked(locked), .h_count(h_count), .v_count(v_count),
      .line_len(line_len), .frame_lines(frame_lines), .err_count(err_count),
      .frame_count(frame_count), .pixel_rgb(pixel_rgb), .probe_hit(probe_hit)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } chk_t;

   chk_t       chk_q[$];
   logic [5:0] pix_exp_q[$];
   int         n_vec = 0;
   int         n_err = 0;

   function automatic logic [31:0] field(input int sel);
      case (sel)
         F_STATE:  return 32'(state);
         F_LOCKED: return 32'(locked);
         F_HCNT:   return 32'(h_count);
         F_VCNT:   return 32'(v_count);
         F_LLEN:   return 32'(line_len);
         F_FLINES: return 32'(frame_lines);
         F_ERR:    return 32'(err_count);
         F_FRM:    return 32'(frame_count);
         F_PIX:    return 32'(pixel_rgb);
         default:  return 32'(probe_hit);
      endcase
   endfunction

   task automatic chk(input string n, input int sel, input int v);
      chk_t c;
      c.name = n;
      c.sel  = sel;
      c.exp  = 32'(v);
      chk_q.push_back(c);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_state"},  F_STATE, 0);
      chk({tag, "_locked"}, F_LOCKED, 0);
      chk({tag, "_hcnt"},   F_HCNT, 0);
      chk({tag, "_vcnt"},   F_VCNT, 0);
      chk({tag, "_llen"},   F_LLEN, 0);
      chk({tag, "_flines"}, F_FLINES, 0);
      chk({tag, "_err"},    F_ERR, 0);
      chk({tag, "_frm"},    F_FRM, 0);
      chk({tag, "_pix"},    F_PIX, 0);
      chk({tag, "_hit"},    F_HIT, 0);
   endtask

   // Monitor: drains pending expectations and scores every probe_hit pulse.
   always @(negedge clk) begin : mon
      chk_t        c;
      logic [31:0] got;
      logic [5:0]  e;
      while (chk_q.size() > 0) begin
         c   = chk_q.pop_front();
         got = field(c.sel);
         n_vec++;
         if (got !== c.exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", c.name, got, c.exp, $time);
         end
      end
      if (probe_hit === 1'b1) begin
         n_vec++;
         if (pix_exp_q.size() == 0) begin
            n_err++;
            $display("FAIL probe_unexpected: got hit with pixel %b, expected no hit at %0t", pixel_rgb, $time);
         end else begin
            e = pix_exp_q.pop_front();
            if (pixel_rgb !== e) begin
               n_err++;
               $display("FAIL probe_pixel: got %b, expected %b at %0t", pixel_rgb, e, $time);
            end
         end
      end
   end

   task automatic put(input logic hs, input logic vs, input logic [5:0] rgb);
      vga_in = {hs, rgb[1], rgb[3], rgb[5], vs, rgb[0], rgb[2], rgb[4]};
      @(posedge clk);
      #1;
   endtask

   task automatic drive_line(input int l, input int c0, input int c1,
                             input logic [5:0] pat, input bit want_hit);
      logic [5:0] rgb;
      for (int c = c0; c <= c1; c++) begin
         rgb = (l == PY && c == PX) ? pat : 6'd0;
         if (l == PY && c == PX && want_hit) pix_exp_q.push_back(pat);
         put(logic'(c >= int'(HS)), logic'(l >= int'(VS)), rgb);
      end
   endtask

   task automatic drive_lines(input int a, input int b, input int short_ln,
                              input logic [5:0] pat, input bit want_hit);
      for (int l = a; l <= b; l++)
         drive_line(l, 0, (l == short_ln) ? int'(HT) - 2 : int'(HT) - 1, pat, want_hit);
   endtask

   task automatic frame(input logic [5:0] pat, input bit want_hit);
      drive_lines(0, int'(VT) - 1, -1, pat, want_hit);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      probe_x = 11'(PX);
      probe_y = 11'd2000;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) put(1'b1, 1'b1, 6'd0);

      // nominal lock sequence
      frame(6'd0, 1'b0);
      chk("f1_state", F_STATE, 1);
      chk("f1_locked", F_LOCKED, 0);
      frame(6'd0, 1'b0);
      chk("f2_state", F_STATE, 2);
      chk("f2_locked", F_LOCKED, 1);
      chk("f2_err", F_ERR, 0);
      chk("f2_frm", F_FRM, 0);
      frame(6'd0, 1'b0);
      chk("f3_state", F_STATE, 2);
      chk("f3_frm", F_FRM, 1);
      chk("f3_flines", F_FLINES, int'(VT));
      chk("f3_llen", F_LLEN, int'(HT));
      chk("f3_err", F_ERR, 0);

      // one short line while locked
      drive_lines(0, 6, 5, 6'd0, 1'b0);
      chk("short_llen", F_LLEN, int'(HT) - 1);
      chk("short_vcnt", F_VCNT, 6);
      chk("short_err", F_ERR, 1);
      chk("short_state", F_STATE, 0);
      chk("short_frm", F_FRM, 2);
      drive_lines(7, int'(VT) - 1, -1, 6'd0, 1'b0);
      frame(6'd0, 1'b0);
      chk("relock1_state", F_STATE, 1);
      frame(6'd0, 1'b0);
      chk("relock2_state", F_STATE, 2);
      chk("relock2_frm", F_FRM, 2);

      // hsync lost while locked
      drive_lines(0, 3, -1, 6'd0, 1'b0);
      repeat (2100) put(1'b1, 1'b1, 6'd0);
      chk("nohs_hcnt", F_HCNT, 2047);
      chk("nohs_vcnt", F_VCNT, 3);
      chk("nohs_err", F_ERR, 2);
      chk("nohs_state", F_STATE, 0);
      chk("nohs_locked", F_LOCKED, 0);

      // error storm: each burst acquires then fails the hsync width check
      for (int i = 1; i <= 300; i++) begin
         repeat (3) put(1'b0, 1'b0, 6'd0);
         repeat (3) put(1'b1, 1'b1, 6'd0);
         if (i == 252) chk("storm_err254", F_ERR, 254);
         if (i == 253) chk("storm_err255", F_ERR, 255);
      end
      chk("storm_err_sat", F_ERR, 255);
      chk("storm_state", F_STATE, 0);
      repeat (3) put(1'b1, 1'b1, 6'd0);

      // probe capture: no hit while acquiring, one hit per locked frame
      probe_y = 11'(PY);
      frame(6'b101101, 1'b0);
      chk("probe_acq_state", F_STATE, 1);
      frame(6'b101101, 1'b1);
      frame(6'b101101, 1'b1);
      frame(6'b010011, 1'b1);
      chk("probe_pix", F_PIX, 6'b010011);
      chk("probe_frm", F_FRM, 5);
      chk("probe_state", F_STATE, 2);
      probe_y = 11'd2000;

      // enable hold mid-line, then asynchronous reset while locked
      drive_lines(0, 4, -1, 6'd0, 1'b0);
      drive_line(5, 0, 19, 6'd0, 1'b0);
      chk("ena_hcnt_pre", F_HCNT, 18);
      ena = 1'b0;
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      chk("ena_hcnt_hold", F_HCNT, 18);
      chk("ena_vcnt_hold", F_VCNT, 5);
      ena = 1'b1;
      drive_line(5, 20, 29, 6'd0, 1'b0);
      #2;
      rst_n = 1'b0;
      chk_all_zero("midrst");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive_line(5, 30, int'(HT) - 1, 6'd0, 1'b0);
      drive_lines(6, int'(VT) - 1, -1, 6'd0, 1'b0);
      chk("post_rst_state", F_STATE, 0);
      frame(6'd0, 1'b0);
      chk("rlk1_state", F_STATE, 1);
      frame(6'd0, 1'b0);
      chk("rlk2_state", F_STATE, 2);
      chk("rlk2_err", F_ERR, 0);
      chk("rlk2_frm", F_FRM, 0);
      chk("rlk2_flines", F_FLINES, int'(VT));

      repeat (3) begin
         @(posedge clk);
         #1;
      end
      n_vec++;
      if (pix_exp_q.size() != 0) begin
         n_err++;
         $display("FAIL probe_missing: got %0d hits outstanding, expected 0", pix_exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/vga_sync_monitor.md
VGA_SYNC_MONITOR -- requirements
Module: vga_sync_monitor

Interface
REQ-001 SHALL have parameter H_TOTAL, default 800, meaning the required number of clk cycles from one hsync assertion to the next.
REQ-002 SHALL have parameter H_SYNC, default 96, meaning the required hsync low width in cycles.
REQ-003 SHALL have parameter V_TOTAL, default 525, meaning the required number of lines per frame.
REQ-004 SHALL have parameter V_SYNC, default 2, meaning the required vsync low width in lines.
REQ-005 SHALL have port clk, input, 1 bit, the single clock, one pixel per cycle.
REQ-006 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-007 SHALL have port ena, input, 1 bit; when low, all registers hold their value.
REQ-008 SHALL have port vga_in, input, 8 bits, the design output pin map: [7]=hsync, [3]=vsync, red={[4],[0]}, green={[5],[1]}, blue={[6],[2]}; syncs are active-low.
REQ-009 SHALL have port probe_x, input, 11 bits, the capture column counted from hsync assertion.
REQ-010 SHALL have port probe_y, input, 11 bits, the capture line counted from the frame boundary.
REQ-011 SHALL have port state, output, 2 bits: 0=SEARCH, 1=ACQUIRE, 2=LOCKED.
REQ-012 SHALL have port locked, output, 1 bit, high iff state==LOCKED.
REQ-013 SHALL have ports h_count and v_count, outputs, 11 bits each, the current pixel and line counters.
REQ-014 SHALL have ports line_len and frame_lines, outputs, 11 bits each, the last measured line length and frame height.
REQ-015 SHALL have port err_count, output, 8 bits, a saturating count of timing errors.
REQ-016 SHALL have port frame_count, output, 8 bits, a wrapping count of locked frames.
REQ-017 SHALL have port pixel_rgb, output, 6 bits {r1,r0,g1,g0,b1,b0}, the captured probe pixel.
REQ-018 SHALL have port probe_hit, output, 1 bit, a one-cycle pulse when pixel_rgb updates.

Function
REQ-019 SHALL register vga_in into stage s1, then s1 into s2; hs_start = s2.hs & ~s1.hs, hs_end = ~s2.hs & s1.hs, with vs_start and vs_end defined the same way; all counter and state updates land 2 cycles after the pin edge.
REQ-020 SHALL on hs_start set h_count=0 and line_len=h_count+1; otherwise increment h_count, saturating at 2047.
REQ-021 SHALL count cycles while s1.hs is low and, on hs_end, compare the count to H_SYNC.
REQ-022 SHALL on vs_start set a pending flag; the frame boundary is the first hs_start with the flag set, including an hs_start in the same cycle as vs_start.
REQ-023 SHALL at the frame boundary set frame_lines=v_count+1, v_count=0 and clear the flag; at any other hs_start, increment v_count, saturating at 2047.
REQ-024 SHALL count hs_starts while vsync is low and, on vs_end, compare that count to V_SYNC.
REQ-025 SHALL define an error as any of, in ACQUIRE or LOCKED only:
- line_len != H_TOTAL at an hs_start;
- hsync width != H_SYNC;
- vsync width != V_SYNC;
- frame_lines != V_TOTAL at a boundary;
- h_count reaching 2047 (no hsync).
REQ-026 SHALL use these state transitions:
- SEARCH -> ACQUIRE at a frame boundary; no checks apply in that cycle.
- ACQUIRE -> LOCKED at the next frame boundary if that cycle has no error.
- Any error in ACQUIRE or LOCKED -> SEARCH, with err_count incremented (saturating at 255).
- An error takes priority over a lock transition in the same cycle.
REQ-027 SHALL never flag an error in SEARCH; h_count saturation in SEARCH is silent.
REQ-028 SHALL increment frame_count (wrapping 255->0) at each frame boundary while already LOCKED and error-free.
REQ-029 SHALL, in LOCKED when h_count==probe_x and v_count==probe_y, load pixel_rgb from the s2 colour bits and pulse probe_hit for one cycle; probe values beyond the counter range never hit.
REQ-030 SHALL keep measurement counters running in all states; only the checks are state-gated.

Reset
REQ-031 SHALL on rst_n low, immediately and independent of clk:
- state=SEARCH, locked=0, probe_hit=0;
- all counters and measurements = 0, pixel_rgb=0;
- s1 and s2 = 8'h88 (syncs idle high).
REQ-032 SHALL resume from SEARCH after rst_n deassertion, including when reset is asserted mid-frame while LOCKED; the next frame boundary is required before ACQUIRE.

Verification
REQ-033 SHALL cover nominal timing: 800x525 frames, hsync low 96 cycles, vsync low 2 lines -> ACQUIRE at the 1st boundary, LOCKED at the 2nd, err_count=0, frame_count=1 after the 3rd.
REQ-034 SHALL cover a single short line: one 799-cycle line while LOCKED -> line_len=799, err_count=1, state=SEARCH, relock after 2 further boundaries.
REQ-035 SHALL cover loss of hsync: hsync held high 2100 cycles while LOCKED -> h_count=2047, err_count+1, SEARCH; a later 300 err events -> err_count stays 255.
REQ-036 SHALL cover probe capture: probe_x=200, probe_y=100, stimulus colour pattern 6'b101101 at that pixel -> probe_hit once per frame, pixel_rgb=6'b101101.
REQ-037 SHALL cover coincident edges: vsync and hsync falling in the same cycle -> the boundary is taken on that hs_start, frame_lines=525.
REQ-038 SHALL cover mid-operation reset: rst_n pulsed low mid-line while LOCKED -> all outputs 0 asynchronously, SEARCH; relock within 2 boundaries.
